// File: rtl/round_timer_pkg.sv
// Shared state encoding and default parameters for the round_timer slice.
package round_timer_pkg;

  localparam int unsigned DefWidth      = 6;
  localparam int unsigned DefPreW       = 4;
  localparam int unsigned DefWarnThresh = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/round_timer_tick_prescaler.sv
// Prescaler for round_timer: emits a one-cycle tick every tick_div_i+1 enabled cycles.
// tick_div_i is sampled live; a count above it wraps through full scale before ticking.
module tick_prescaler #(
  parameter int unsigned PRE_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [PRE_W-1:0] tick_div_i,
  output logic             tick_c_o
);

  logic [PRE_W-1:0] cnt_q, cnt_d;

  assign tick_c_o = en_i && !clr_i && (cnt_q == tick_div_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_c_o ? '0 : cnt_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/round_timer.sv
// Programmable round countdown timer with pause, abort and auto-reload.
// Optional low-time warning output enabled by defining ROUND_TIMER_WARN_EN.
module round_timer
  import round_timer_pkg::*;
#(
  parameter int unsigned WIDTH       = DefWidth,
  parameter int unsigned PRE_W       = DefPreW,
  parameter int unsigned WARN_THRESH = DefWarnThresh
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  input  logic [PRE_W-1:0] tick_div,
  output logic [WIDTH-1:0] remaining,
  output logic             running,
  output logic             expired,
  output logic             hit_target,
  output logic             warn
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             auto_q, auto_d;
  logic             expired_q, expired_d;
  logic             active, idle_like, pre_en, pre_clr, tick;

  assign active    = (state_q == RUN) || (state_q == PAUSE);
  assign idle_like = (state_q == IDLE) || (state_q == DONE);
  assign pre_clr   = abort || (idle_like && start);
  assign pre_en    = active && !pause && !abort;

  tick_prescaler #(
    .PRE_W (PRE_W)
  ) u_pre (
    .clk_i      (clk),
    .rst_ni     (reset),
    .en_i       (pre_en),
    .clr_i      (pre_clr),
    .tick_div_i (tick_div),
    .tick_c_o   (tick)
  );

  // Next-state: abort beats start, start beats pause/tick; a paused cycle never ticks.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    reload_d    = reload_q;
    auto_d      = auto_q;
    expired_d   = 1'b0;
    if (abort) begin
      state_d     = IDLE;
      remaining_d = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            reload_d    = load_val;
            auto_d      = auto_reload;
            remaining_d = load_val;
            if (load_val == '0) begin
              state_d   = DONE;
              expired_d = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN, PAUSE: begin
          state_d = pause ? PAUSE : RUN;
          if (tick) begin
            if (remaining_q == WIDTH'(1)) begin
              expired_d = 1'b1;
              if (auto_q) begin
                remaining_d = reload_q;
              end else begin
                remaining_d = '0;
                state_d     = DONE;
              end
            end else begin
              remaining_d = remaining_q - WIDTH'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      reload_q    <= '0;
      auto_q      <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      reload_q    <= reload_d;
      auto_q      <= auto_d;
      expired_q   <= expired_d;
    end
  end

  assign remaining  = remaining_q;
  assign expired    = expired_q;
  assign running    = active;
  assign hit_target = idle_like;

`ifdef ROUND_TIMER_WARN_EN
  logic warn_q, warn_d;

  // Warning is computed from next-state values so it lines up with remaining.
  assign warn_d = ((state_d == RUN) || (state_d == PAUSE)) &&
                  (remaining_d <= WIDTH'(WARN_THRESH)) && (remaining_d != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign warn = warn_q;
`else
  assign warn = 1'b0 & (WARN_THRESH != 0);
`endif

endmodule

// File: doc/round_timer.md
# round_timer

Parametrised countdown timer for game-round and time-limit control. It generalises the fixed one-shot 60 s timer with the following additions:
- programmable count and prescaler;
- pause, abort and auto-reload;
- a live remaining-count output for display logic.

It sits between the game FSM, which starts, pauses and aborts rounds, and the display/scoring logic, which consumes `remaining`, `expired` and `hit_target`.

## Interface
- `WIDTH`, 6: width of the round count and `load_val`.
- `PRE_W`, 4: width of the prescaler and `tick_div`.
- `WARN_THRESH`, 2: warning threshold. Used only when `ROUND_TIMER_WARN_EN` is defined.

Ports (clock and reset first):
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  load `load_val` and begin counting. Honoured in IDLE and DONE only.
- `pause`  in  1  level. While high in RUN/PAUSE, counting is frozen.
- `abort`  in  1  return to IDLE from any state.
- `auto_reload`  in  1  mode select, latched at start. 1 = reload on expiry and keep running.
- `load_val`  in  WIDTH  round length in ticks, latched at start.
- `tick_div`  in  PRE_W  prescaler terminal. One tick every `tick_div`+1 counting cycles. Sampled live.
- `remaining`  out  WIDTH  ticks left.
- `running`  out  1  high in RUN and PAUSE.
- `expired`  out  1  one-cycle pulse on reaching zero.
- `hit_target`  out  1  high in IDLE or DONE (timer not active).
- `warn`  out  1  low-time warning. Constant 0 when the feature is compiled out.

## Operation
- States:
  - IDLE (reset state)
  - RUN
  - PAUSE
  - DONE
- Priority per cycle: reset low > abort > start > pause/tick.
- IDLE/DONE with `start`=1:
  - latch `load_val` and `auto_reload`;
  - set `remaining`=`load_val` and prescaler=0;
  - go to RUN.
- `start` with `load_val`=0: go directly to DONE, `remaining`=0, `expired` pulses once. `auto_reload` is ignored in this case.
- RUN with `pause`=0:
  - the prescaler increments;
  - at `tick_div` it wraps to 0 and `remaining` decrements.
- RUN with `pause`=1: go to PAUSE. The prescaler and `remaining` hold during that cycle.
- PAUSE: everything holds. When `pause`=0, go back to RUN, resuming from the held prescaler value.
- Tick with `remaining`=1:
  - next cycle `remaining`=0 and `expired`=1;
  - with the latched auto_reload=0: go to DONE;
  - with the latched auto_reload=1: stay in RUN, with `remaining` reloaded from the latched value on the same edge, so `remaining` never shows 0.
- `start` in RUN/PAUSE is ignored.
- DONE holds `remaining`=0 until `start` or `abort`.
- `abort`: go to IDLE next cycle with `remaining`=0 and the prescaler cleared. `abort` wins over a simultaneous `start` or expiry.
- A change of `tick_div` mid-run takes effect at once. If the prescaler is already above the new `tick_div`, it wraps at its full-scale value before ticking.

## Timing
- Reset values:
  - `remaining`=0, `running`=0, `expired`=0, `warn`=0
  - `hit_target`=1
  - state IDLE
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs.
- `start` sampled at edge N: RUN and `remaining`=`load_val` are visible from cycle N+1.
- Expiry with no pause: `expired` is high in cycle N+1+`load_val`·(`tick_div`+1).
- Each pause cycle delays expiry by exactly one cycle.
- Auto-reload period: `load_val`·(`tick_div`+1) cycles between `expired` pulses.
- `abort` sampled at N: `hit_target`=1 and `running`=0 at N+1.

## Configuration
- Macro: `ROUND_TIMER_WARN_EN`.
- Defined: `warn` = `running` AND `remaining` ≤ `WARN_THRESH` AND `remaining` ≠ 0, registered together with `remaining`.
- Undefined: `warn` tied to 0 and the comparator is not built. The port list is identical in both builds.

## Structure
- Package `round_timer_pkg` holds:
  - the state enum (IDLE, RUN, PAUSE, DONE);
  - the default parameter constants.
- Sub-module `tick_prescaler`:
  - contains the PRE_W counter;
  - inputs: enable, clear, `tick_div`;
  - output: a one-cycle tick.

## Test plan
WIDTH=6, PRE_W=4 throughout.
- Reset: hold `reset`=0 for 3 cycles with `start`=1 → `remaining`=0, `hit_target`=1, `running`=0, `expired`=0 throughout.
- One-shot: `load_val`=5, `tick_div`=3, `start` at cycle 0 → `remaining` steps 5→0 every 4 cycles. `expired` pulses at cycle 21, after which `hit_target`=1 and state is DONE.
- Pause: same as one-shot plus `pause` high for cycles 6–15 → `remaining` frozen during the pause, `expired` at cycle 31.
- Auto-reload and abort: `load_val`=2, `tick_div`=0, `auto_reload`=1 → `expired` at cycles 3, 5, 7, … with `remaining` alternating 2,1. Assert `abort` together with `start` at cycle 8 → IDLE at cycle 9, `remaining`=0.
- Zero load: `load_val`=0 with `start` → DONE next cycle, `expired` high for exactly one cycle. `start` during RUN in another run → ignored.
- Warning (`ROUND_TIMER_WARN_EN`, `WARN_THRESH`=2): `load_val`=4 → `warn` high while `remaining` is 2 or 1, low at 0, always 0 in the build without the macro.
